debounce_scheduler: RTL and testbench
=====================================

DEBOUNCE_SCHEDULER -- requirements
Module: debounce_scheduler

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of switch channels (2..8).
REQ-002 SHALL have parameter STABLE_CYCLES, default 50000, meaning clk cycles a level must hold to commit (1 ms at 50 MHz).
REQ-003 SHALL have parameter CNT_W, default 16, meaning shared counter width; STABLE_CYCLES <= 2^CNT_W.
REQ-004 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port sw_in  input  N_CH  raw, asynchronous, bouncing switch levels.
REQ-007 SHALL have port sw_level  output  N_CH  debounced level per channel.
REQ-008 SHALL have port evt_valid  output  1  committed-change event pending.
REQ-009 SHALL have port evt_ready  input  1  consumer accepts event when high with evt_valid.
REQ-010 SHALL have port evt_ch  output  clog2(N_CH)  channel of pending event.
REQ-011 SHALL have port evt_rise  output  1  1 = committed 0->1 (press), 0 = committed 1->0 (release).
REQ-012 SHALL have port evt_overflow  output  1  sticky; event dropped because slot was full.
REQ-013 SHALL have port busy  output  1  high while FSM not in IDLE.

Function
REQ-014 SHALL pass each sw_in bit through a 2-FF synchronizer; sync[i] = second stage.
REQ-015 SHALL define mismatch[i] = sync[i] XOR sw_level[i].
REQ-016 SHALL share one CNT_W-bit stable counter among all channels; one channel timed at a time.
REQ-017 SHALL implement FSM states IDLE, TIMING, COMMIT; busy = (state != IDLE).
REQ-018 SHALL, in IDLE with any mismatch, select cur_ch round-robin starting at rr_ptr+1 (mod N_CH), clear counter, enter TIMING next edge.
REQ-019 SHALL, in IDLE with no mismatch, remain in IDLE with counter held at 0.
REQ-020 SHALL, in TIMING with mismatch[cur_ch]=0 (bounce back), abort to IDLE, set rr_ptr=cur_ch, emit no event.
REQ-021 SHALL, in TIMING with mismatch[cur_ch]=1, increment counter; at counter==STABLE_CYCLES-1 enter COMMIT next edge.
REQ-022 SHALL, in COMMIT, invert sw_level[cur_ch], set rr_ptr=cur_ch, return to IDLE next edge.
REQ-023 SHALL make sw_level toggle on edge E+STABLE_CYCLES+3, where E = edge sampling the new stable input into sync stage 1 and FSM idle at E+1.
REQ-024 SHALL, on COMMIT with slot free (evt_valid=0, or evt_valid=1 and evt_ready=1 same cycle), load evt_ch=cur_ch, evt_rise=new level, evt_valid=1.
REQ-025 SHALL, on COMMIT with evt_valid=1 and evt_ready=0, keep old event unchanged, still update sw_level, set evt_overflow=1.
REQ-026 SHALL clear evt_valid on evt_valid&evt_ready when no COMMIT loads the slot that cycle.
REQ-027 SHALL hold evt_ch/evt_rise stable while evt_valid=1 and evt_ready=0.
REQ-028 SHALL ignore changes on channels other than cur_ch during TIMING; they are serviced in later IDLE arbitration.
REQ-029 SHALL never let the counter wrap; it only counts in TIMING and clears on IDLE entry.

Reset
REQ-030 SHALL, on rst=0, immediately clear sync regs, sw_level, counter, evt_valid, evt_ch, evt_rise, evt_overflow to 0, state to IDLE, rr_ptr to N_CH-1.
REQ-031 SHALL, on reset during TIMING/COMMIT, discard the in-progress channel with no event; sw_in still high after release restarts timing from 0.
REQ-032 SHALL clear evt_overflow only by reset.

Verification (STABLE_CYCLES=8, N_CH=4)
REQ-033 SHALL cover: reset, sw_in=0000, then sw_in[0]=1 held -> sw_level[0]=1 on edge E+11, evt_valid=1, evt_ch=0, evt_rise=1.
REQ-034 SHALL cover: sw_in[1] high 5 cycles then low -> abort to IDLE, no event, sw_level=0000, busy low within 3 cycles.
REQ-035 SHALL cover: sw_in=1010 same edge, evt_ready=1 -> events ch1 then ch3, ch3 committed exactly 10 edges after ch1.
REQ-036 SHALL cover: evt_ready=0, commits on ch0 then ch2 -> evt_ch stays 0, evt_overflow=1, sw_level=0101.
REQ-037 SHALL cover: ch0 at sw_level=1, sw_in[0] 1->0 held -> sw_level[0]=0, evt_ch=0, evt_rise=0.
REQ-038 SHALL cover: rst=0 mid-TIMING on ch2 -> outputs 0 same cycle without clock edge; after release with sw_in[2]=1, commit at E+11.

Source files
------------

// File: rtl/debounce_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : debounce_scheduler
// Brief    : Multi-channel switch debouncer that times channels one at a time
//            with a shared counter, and reports committed edges through a
//            one-deep valid/ready event slot with a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_scheduler #(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         sw_in,
    output logic [N_CH-1:0]         sw_level,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(N_CH)-1:0] evt_ch,
    output logic                    evt_rise,
    output logic                    evt_overflow,
    output logic                    busy
);

    localparam int c_ch_w = $clog2(N_CH);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_timing = 2'd1;
    localparam logic [1:0] c_commit = 2'd2;

    localparam logic [CNT_W-1:0]  c_last_cnt = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_ch_w-1:0] c_last_ch  = c_ch_w'(N_CH - 1);

    logic [N_CH-1:0]   r_sync1;
    logic [N_CH-1:0]   r_sync2;
    logic [N_CH-1:0]   r_level;
    logic [CNT_W-1:0]  r_count;
    logic [1:0]        r_state;
    logic [c_ch_w-1:0] r_cur_ch;
    logic [c_ch_w-1:0] r_rr_ptr;
    logic              r_evt_valid;
    logic [c_ch_w-1:0] r_evt_ch;
    logic              r_evt_rise;
    logic              r_evt_ovf;

    logic [N_CH-1:0]   w_mismatch;
    logic              w_any;
    logic              w_found;
    logic [c_ch_w-1:0] w_next_ch;
    logic              w_commit;
    logic              w_slot_free;
    int                v_idx;
    logic [c_ch_w-1:0] v_ch;

    assign w_mismatch  = r_sync2 ^ r_level;
    assign w_any       = |w_mismatch;
    assign w_commit    = (r_state == c_commit);
    assign w_slot_free = !r_evt_valid || evt_ready;

    // Round-robin search begins one past the last serviced channel.
    always_comb begin
        w_next_ch = r_rr_ptr;
        w_found   = 1'b0;
        v_idx     = 0;
        v_ch      = '0;
        for (int k = 1; k <= N_CH; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= N_CH) begin
                v_idx = v_idx - N_CH;
            end
            v_ch = v_idx[c_ch_w-1:0];
            if (!w_found && w_mismatch[v_ch]) begin
                w_found   = 1'b1;
                w_next_ch = v_ch;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_level  <= '0;
            r_count  <= '0;
            r_state  <= c_idle;
            r_cur_ch <= '0;
            r_rr_ptr <= c_last_ch;
        end else begin
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
            case (r_state)
                c_idle: begin
                    r_count <= '0;
                    if (w_any) begin
                        r_cur_ch <= w_next_ch;
                        r_state  <= c_timing;
                    end
                end
                c_timing: begin
                    // Input fell back to the committed level: a bounce, drop it.
                    if (!w_mismatch[r_cur_ch]) begin
                        r_state  <= c_idle;
                        r_rr_ptr <= r_cur_ch;
                        r_count  <= '0;
                    end else if (r_count == c_last_cnt) begin
                        r_state <= c_commit;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                c_commit: begin
                    r_level[r_cur_ch] <= ~r_level[r_cur_ch];
                    r_rr_ptr          <= r_cur_ch;
                    r_count           <= '0;
                    r_state           <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    // A commit into an occupied slot keeps the pending event and flags the loss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
            r_evt_rise  <= 1'b0;
            r_evt_ovf   <= 1'b0;
        end else begin
            if (w_commit) begin
                if (w_slot_free) begin
                    r_evt_valid <= 1'b1;
                    r_evt_ch    <= r_cur_ch;
                    r_evt_rise  <= ~r_level[r_cur_ch];
                end else begin
                    r_evt_ovf <= 1'b1;
                end
            end else if (r_evt_valid && evt_ready) begin
                r_evt_valid <= 1'b0;
            end
        end
    end

    assign sw_level     = r_level;
    assign evt_valid    = r_evt_valid;
    assign evt_ch       = r_evt_ch;
    assign evt_rise     = r_evt_rise;
    assign evt_overflow = r_evt_ovf;
    assign busy         = (r_state != c_idle);

endmodule
`default_nettype wire

// File: tb/tb_debounce_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_scheduler
// Brief    : Directed bench for debounce_scheduler with an event scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_scheduler;

    localparam int N_CH          = 4;
    localparam int STABLE_CYCLES = 8;
    localparam int CNT_W         = 4;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic [3:0] sw_in     = 4'b0000;
    logic       evt_ready = 1'b0;
    logic [3:0] sw_level;
    logic       evt_valid;
    logic [1:0] evt_ch;
    logic       evt_rise;
    logic       evt_overflow;
    logic       busy;

    typedef struct packed {
        logic [1:0] ch;
        logic       rise;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    debounce_scheduler #(
        .N_CH          (N_CH),
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_in        (sw_in),
        .sw_level     (sw_level),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_ch       (evt_ch),
        .evt_rise     (evt_rise),
        .evt_overflow (evt_overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [1:0] ch, input logic rise);
        exp_t e;
        e.ch   = ch;
        e.rise = rise;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst       = 1'b0;
        sw_in     = 4'b0000;
        evt_ready = ready;
        step(2);
        rst = 1'b1;
    endtask

    // Monitor: every accepted event must match the head of the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst && evt_valid && evt_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL evt_unexpected: got ch=%0d rise=%0d, required no event", evt_ch, evt_rise);
                end else begin
                    e = exp_q.pop_front();
                    if (evt_ch !== e.ch || evt_rise !== e.rise) begin
                        n_errors++;
                        $display("FAIL evt_payload: got ch=%0d rise=%0d, required ch=%0d rise=%0d",
                                 evt_ch, evt_rise, e.ch, e.rise);
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        #1 rst = 1'b0;
        step(1);
        check("rst_level",    32'(sw_level),     0);
        check("rst_valid",    32'(evt_valid),    0);
        check("rst_ch",       32'(evt_ch),       0);
        check("rst_rise",     32'(evt_rise),     0);
        check("rst_overflow", 32'(evt_overflow), 0);
        check("rst_busy",     32'(busy),         0);

        // Single press on ch0: level toggles 12 negedges after drive
        do_reset(1'b1);
        sw_in = 4'b0001;
        push_exp(2'd0, 1'b1);
        step(11);
        check("press_lvl_early", 32'(sw_level), 0);
        step(1);
        check("press_lvl",   32'(sw_level),  32'h1);
        check("press_valid", 32'(evt_valid), 1);
        check("press_ch",    32'(evt_ch),    0);
        check("press_rise",  32'(evt_rise),  1);

        // Bounce on ch1: held 5 cycles then released -> abort, no event
        do_reset(1'b1);
        sw_in = 4'b0010;
        step(4);
        check("bounce_busy_hi", 32'(busy), 1);
        step(1);
        sw_in = 4'b0000;
        step(3);
        check("bounce_busy_lo", 32'(busy),      0);
        check("bounce_level",   32'(sw_level),  0);
        check("bounce_valid",   32'(evt_valid), 0);
        step(15);
        check("bounce_level_late", 32'(sw_level), 0);

        // Simultaneous ch1 and ch3: round-robin order, 10 edges apart
        do_reset(1'b1);
        sw_in = 4'b1010;
        push_exp(2'd1, 1'b1);
        push_exp(2'd3, 1'b1);
        step(11);
        check("rr_lvl_none", 32'(sw_level), 0);
        step(1);
        check("rr_lvl_ch1", 32'(sw_level), 32'h2);
        check("rr_evt_ch1", 32'(evt_ch),   1);
        step(9);
        check("rr_lvl_ch3_early", 32'(sw_level), 32'h2);
        step(1);
        check("rr_lvl_ch3", 32'(sw_level), 32'ha);
        check("rr_evt_ch3", 32'(evt_ch),   3);

        // Overflow: consumer stalled, second commit dropped
        do_reset(1'b0);
        sw_in = 4'b0001;
        push_exp(2'd0, 1'b1);
        step(12);
        check("ovf_first_valid", 32'(evt_valid),    1);
        check("ovf_first_ch",    32'(evt_ch),       0);
        check("ovf_first_flag",  32'(evt_overflow), 0);
        sw_in = 4'b0101;
        step(12);
        check("ovf_level", 32'(sw_level),     32'h5);
        check("ovf_ch",    32'(evt_ch),       0);
        check("ovf_rise",  32'(evt_rise),     1);
        check("ovf_valid", 32'(evt_valid),    1);
        check("ovf_flag",  32'(evt_overflow), 1);
        evt_ready = 1'b1;
        step(1);
        check("ovf_drained", 32'(evt_valid),    0);
        check("ovf_sticky",  32'(evt_overflow), 1);

        // Release on ch0 after a committed press
        do_reset(1'b1);
        sw_in = 4'b0001;
        push_exp(2'd0, 1'b1);
        step(12);
        check("rel_pressed", 32'(sw_level), 32'h1);
        sw_in = 4'b0000;
        push_exp(2'd0, 1'b0);
        step(11);
        check("rel_lvl_early", 32'(sw_level), 32'h1);
        step(1);
        check("rel_level", 32'(sw_level),  0);
        check("rel_valid", 32'(evt_valid), 1);
        check("rel_ch",    32'(evt_ch),    0);
        check("rel_rise",  32'(evt_rise),  0);

        // Asynchronous reset mid-timing on ch2, then restart from zero
        do_reset(1'b1);
        sw_in = 4'b0100;
        step(6);
        check("arst_busy_before", 32'(busy), 1);
        #2 rst = 1'b0;
        #1;
        check("arst_busy",  32'(busy),      0);
        check("arst_level", 32'(sw_level),  0);
        check("arst_valid", 32'(evt_valid), 0);
        step(2);
        rst = 1'b1;
        push_exp(2'd2, 1'b1);
        step(11);
        check("arst_lvl_early", 32'(sw_level), 0);
        step(1);
        check("arst_level_commit", 32'(sw_level), 32'h4);
        check("arst_evt_ch",       32'(evt_ch),   2);

        step(5);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
